// File: rtl/constraint_sampler_driver.sv
// Stimulus stage for generated constraint checkers: fills candidates from an xorshift64
// generator, retries until the checker accepts, and hands accepted candidates off over valid/ready.
module constraint_sampler_driver #(
    parameter int          VEC_W     = 551,
    parameter logic [63:0] SEED      = 64'h0123_4567_89AB_CDEF,
    parameter int          MAX_TRIES = 1024,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_samples,
    output logic [VEC_W-1:0] cand_o,
    input  logic             x_i,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [VEC_W-1:0] sample_data,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] tries_total,
    output logic [CNT_W-1:0] hits
);

    localparam int NW   = (VEC_W + 63) / 64;
    localparam int WC_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int RJ_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [63:0]     EFF_SEED = (SEED == 64'd0) ? 64'h9E37_79B9_7F4A_7C15 : SEED;
    localparam logic [WC_W-1:0] WC_LAST  = WC_W'(NW - 1);
    localparam logic [RJ_W-1:0] REJ_LAST = RJ_W'(MAX_TRIES - 1);

    typedef enum logic [2:0] {IDLE, FILL, CHECK, EMIT, DONE} state_t;

    state_t           state;
    logic [63:0]      s;
    logic [63:0]      t1;
    logic [63:0]      t2;
    logic [63:0]      s_next;
    logic [VEC_W-1:0] cand;
    logic [WC_W-1:0]  word_cnt;
    logic [RJ_W-1:0]  rej;
    logic [15:0]      target;
    logic [CNT_W-1:0] hits_inc;
    logic [CNT_W-1:0] tries_inc;

    always_comb begin
        t1        = s ^ (s << 13);
        t2        = t1 ^ (t1 >> 7);
        s_next    = t2 ^ (t2 << 17);
        hits_inc  = (&hits) ? hits : hits + CNT_W'(1);
        tries_inc = (&tries_total) ? tries_total : tries_total + CNT_W'(1);
    end

    // The candidate register is the only source for both the checker and the consumer.
    assign cand_o      = cand;
    assign sample_data = cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s            <= EFF_SEED;
            cand         <= '0;
            word_cnt     <= '0;
            rej          <= '0;
            target       <= '0;
            tries_total  <= '0;
            hits         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tries_total <= '0;
                        hits        <= '0;
                        fail        <= 1'b0;
                        rej         <= '0;
                        word_cnt    <= '0;
                        target      <= num_samples;
                        if (num_samples == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                            busy  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    // Shifting whole words up drops the excess bits of the oldest word.
                    s    <= s_next;
                    cand <= VEC_W'({cand, s_next});
                    if (word_cnt == WC_LAST) begin
                        word_cnt <= '0;
                        state    <= CHECK;
                    end else begin
                        word_cnt <= word_cnt + WC_W'(1);
                    end
                end
                CHECK: begin
                    tries_total <= tries_inc;
                    if (x_i) begin
                        rej          <= '0;
                        state        <= EMIT;
                        sample_valid <= 1'b1;
                    end else if (rej == REJ_LAST) begin
                        fail  <= 1'b1;
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        rej   <= rej + RJ_W'(1);
                        state <= FILL;
                    end
                end
                EMIT: begin
                    if (sample_ready) begin
                        hits         <= hits_inc;
                        sample_valid <= 1'b0;
                        if (hits_inc == CNT_W'(target)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
